// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared constants and FSM encoding for the multiplier dispatch stage
package mul_pkg;

    localparam int MUL_WIDTH       = 32;
    localparam int MUL_LATENCY_DEF = 34;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        HOLD  = 2'b11
    } mul_state_e;

endpackage

// File: rtl/mul_dispatch_if.sv
// rtl/mul_dispatch_if.sv - operand and result valid/ready streams of mul_dispatch
interface mul_dispatch_if #(
    parameter int WIDTH = mul_pkg::MUL_WIDTH
);

    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;

    modport master (
        output op_valid, op_a, op_b, res_ready,
        input  op_ready, res_valid, res_data
    );

    modport slave (
        input  op_valid, op_a, op_b, res_ready,
        output op_ready, res_valid, res_data
    );

endinterface

// File: rtl/mul_op_fifo.sv
// rtl/mul_op_fifo.sv - synchronous operand-pair FIFO, power-of-2 depth, no bypass
module mul_op_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          empty,
    output logic          full
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_MAX);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mul_dispatch.sv
// rtl/mul_dispatch.sv - streams operand pairs into the start/busy multiplier, one in flight
// Optional done_count statistics output is enabled with MUL_DISPATCH_STATS_EN.
module mul_dispatch
    import mul_pkg::*;
#(
    parameter int WIDTH       = MUL_WIDTH,
    parameter int DEPTH       = 4,
    parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
    input  logic             clk,
    input  logic             rst,
    mul_dispatch_if.slave    bus,
    output logic [WIDTH-1:0] mul_in1,
    output logic [WIDTH-1:0] mul_in2,
    output logic             mul_start,
    input  logic             mul_busy,
    input  logic [WIDTH-1:0] mul_out,
    output logic             fifo_empty,
    output logic             fifo_full
`ifdef MUL_DISPATCH_STATS_EN
    ,
    output logic [15:0]      done_count
`endif
);

    localparam int            CW       = $clog2(MUL_LATENCY + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    mul_state_e         state;
    mul_state_e         state_nx;
    logic [CW-1:0]      cnt;
    logic               push;
    logic               pop;
    logic [2*WIDTH-1:0] head;
    logic               res_valid_q;
    logic [WIDTH-1:0]   res_data_q;

    assign bus.op_ready  = !fifo_full;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign push          = bus.op_valid && !fifo_full;

    mul_op_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({bus.op_a, bus.op_b}),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !mul_busy) begin
                    pop      = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE:   state_nx = WAIT;
            WAIT:    if (cnt == CNT_LAST) state_nx = HOLD;
            HOLD:    if (bus.res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // mul_start is registered from the pop so it is high for exactly the ISSUE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_start   <= 1'b0;
            mul_in1     <= '0;
            mul_in2     <= '0;
            cnt         <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            mul_start <= pop;
            if (pop) begin
                mul_in1 <= head[2*WIDTH-1:WIDTH];
                mul_in2 <= head[WIDTH-1:0];
            end
            case (state)
                ISSUE: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        res_data_q  <= mul_out;
                        res_valid_q <= 1'b1;
                    end
                end
                HOLD:    if (bus.res_ready) res_valid_q <= 1'b0;
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef MUL_DISPATCH_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                              done_count <= 16'h0000;
        else if (bus.res_valid && bus.res_ready) done_count <= done_count + 16'h0001;
    end
`endif

endmodule

// File: tb/tb_mul_dispatch.sv
// tb/tb_mul_dispatch.sv - self-checking bench for mul_dispatch with a latency-accurate multiplier model
module tb_mul_dispatch;

    localparam int W = 32;
    localparam int D = 4;
    localparam int L = 34;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] mul_in1;
    logic [W-1:0] mul_in2;
    logic [W-1:0] mul_out;
    logic         mul_start;
    logic         mul_busy;
    logic         fifo_empty;
    logic         fifo_full;
    logic         busy_force = 1'b0;
`ifdef MUL_DISPATCH_STATS_EN
    logic [15:0]  done_count;
`endif

    always #5 clk = ~clk;

    mul_dispatch_if #(.WIDTH(W)) bus ();

    mul_dispatch #(
        .WIDTH       (W),
        .DEPTH       (D),
        .MUL_LATENCY (L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .mul_in1    (mul_in1),
        .mul_in2    (mul_in2),
        .mul_start  (mul_start),
        .mul_busy   (mul_busy),
        .mul_out    (mul_out),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full)
`ifdef MUL_DISPATCH_STATS_EN
        ,
        .done_count (done_count)
`endif
    );

    // Multiplier model: product appears L cycles after start is sampled, garbage before.
    int           mcnt;
    logic [W-1:0] mul_out_r;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcnt      <= 0;
            mul_out_r <= 32'hDEADBEEF;
        end else if (mul_start) begin
            mcnt      <= 1;
            mul_out_r <= 32'hDEADBEEF;
        end else if (mcnt != 0) begin
            mcnt <= (mcnt == L - 1) ? 0 : mcnt + 1;
            if (mcnt == L - 1) mul_out_r <= mul_in1 * mul_in2;
        end
    end
    assign mul_out  = mul_out_r;
    assign mul_busy = busy_force || (mcnt != 0);

    int           cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_fail = 0;
    int           n_res = 0;
    int           stat_hs = 0;
    int           hs_prev = 0;
    int           hs_last = 0;
    logic [W-1:0] last_res = '0;
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Per-cycle compare process against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            prev_hold = 1'b0;
        end else begin
            check("op_ready_vs_full", 64'(bus.op_ready), 64'(!fifo_full));
`ifdef MUL_DISPATCH_STATS_EN
            check("done_count", 64'(done_count), 64'(stat_hs[15:0]));
`endif
            if (prev_hold) begin
                check("res_valid_held", 64'(bus.res_valid), 64'(1));
                check("res_data_stable", 64'(bus.res_data), 64'(prev_data));
            end
            if (bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_result: got %0h expected none", bus.res_data);
                end else begin
                    check("res_data_order", 64'(bus.res_data), 64'(exp_q.pop_front()));
                end
                last_res = bus.res_data;
                n_res++;
                stat_hs++;
                hs_prev = hs_last;
                hs_last = cyc;
            end
            prev_hold = bus.res_valid && !bus.res_ready;
            prev_data = bus.res_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, output int acc_cyc);
        bit ok = 1'b0;
        bus.op_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        acc_cyc      = -1;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            ok = bus.op_ready;
            tick();
        end
        if (ok) begin
            exp_q.push_back(a * b);
            acc_cyc = cyc;
        end else begin
            n_cmp++;
            n_fail++;
            $display("FAIL push_timeout: got op_ready=0 expected 1 within 500 cycles");
        end
        bus.op_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            tick();
            done = (exp_q.size() == 0) && fifo_empty && !bus.res_valid;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c4, n0;
        bus.op_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.res_ready = 1'b1;
        #3 rst = 1'b0;
        #20;
        check("rst_op_ready", 64'(bus.op_ready), 64'(1));
        check("rst_fifo_empty", 64'(fifo_empty), 64'(1));
        check("rst_fifo_full", 64'(fifo_full), 64'(0));
        check("rst_res_valid", 64'(bus.res_valid), 64'(0));
        check("rst_mul_start", 64'(mul_start), 64'(0));
        check("rst_res_data", 64'(bus.res_data), 64'(0));
        check("rst_mul_in1", 64'(mul_in1), 64'(0));
        check("rst_mul_in2", 64'(mul_in2), 64'(0));
        tick();
        rst = 1'b1;
        tick();

        // Single operation: pin the start pulse and the E0+36 result edge.
        push(32'd3, 32'd5, c0);
        for (int k = 1; k <= 37; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                check("t1_start_pulse", 64'(mul_start), 64'(1));
                check("t1_in1", 64'(mul_in1), 64'(3));
                check("t1_in2", 64'(mul_in2), 64'(5));
            end
            if (k == 2)  check("t1_start_once", 64'(mul_start), 64'(0));
            if (k == 35) check("t1_not_early", 64'(bus.res_valid), 64'(0));
            if (k == 36) begin
                check("t1_res_valid", 64'(bus.res_valid), 64'(1));
                check("t1_res_data", 64'(bus.res_data), 64'(15));
            end
            if (k == 37) check("t1_res_clear", 64'(bus.res_valid), 64'(0));
        end
        #1;
        drain();

        push(32'h0000FFFF, 32'h00010001, c0);
        drain();
        check("t2_ffff", 64'(last_res), 64'hFFFFFFFF);
        push(32'hFFFFFFFF, 32'd2, c0);
        drain();
        check("t2_overflow", 64'(last_res), 64'hFFFFFFFE);
`ifdef MUL_DISPATCH_STATS_EN
        check("stats_three", 64'(done_count), 64'(3));
`endif

        // Back-pressure: 5 pairs, 4 buffered plus 1 in flight.
        bus.res_ready = 1'b0;
        push(32'd2, 32'd3, c0);
        push(32'd4, 32'd5, c4);
        push(32'd6, 32'd7, c4);
        push(32'd8, 32'd9, c4);
        push(32'd10, 32'd11, c4);
        check("t3_back_to_back", 64'(c4 - c0), 64'(4));
        check("t3_full", 64'(fifo_full), 64'(1));
        check("t3_op_ready", 64'(bus.op_ready), 64'(0));
        n0 = n_res;
        repeat (60) tick();
        check("t3_hold_valid", 64'(bus.res_valid), 64'(1));
        check("t3_hold_data", 64'(bus.res_data), 64'(6));
        check("t3_no_handshake", 64'(n_res), 64'(n0));
        bus.res_ready = 1'b1;
        drain();
        check("t3_count", 64'(n_res - n0), 64'(5));
        check("t3_throughput", 64'(hs_last - hs_prev), 64'(L + 3));

        // Busy deferral.
        busy_force = 1'b1;
        push(32'd7, 32'd9, c0);
        push(32'd11, 32'd13, c0);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (mul_start || fifo_empty) begin
                check("t4_deferred_start", 64'(mul_start), 64'(0));
                check("t4_deferred_queue", 64'(fifo_empty), 64'(0));
            end
        end
        check("t4_still_queued", 64'(fifo_empty), 64'(0));
        busy_force = 1'b0;
        @(posedge clk);
        #1;
        check("t4_issue_next_edge", 64'(mul_start), 64'(1));
        check("t4_issue_in1", 64'(mul_in1), 64'(7));
        #1;
        drain();

        // Reset during WAIT with work queued.
        push(32'd1, 32'd2, c0);
        push(32'd3, 32'd4, c0);
        push(32'd5, 32'd6, c0);
        repeat (10) tick();
        rst = 1'b0;
        #1;
        exp_q.delete();
        stat_hs = 0;
        check("t5_res_valid", 64'(bus.res_valid), 64'(0));
        check("t5_mul_start", 64'(mul_start), 64'(0));
        check("t5_mul_in1", 64'(mul_in1), 64'(0));
        check("t5_res_data", 64'(bus.res_data), 64'(0));
        check("t5_fifo_empty", 64'(fifo_empty), 64'(1));
        check("t5_op_ready", 64'(bus.op_ready), 64'(1));
        repeat (2) tick();
        rst = 1'b1;
        n0 = n_res;
        repeat (100) tick();
        check("t5_no_result", 64'(n_res), 64'(n0));
        check("t5_empty_after", 64'(fifo_empty), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_dispatch.md
Name: mul_dispatch

Overview:
- Upstream operand stage for the iterative unsigned multiplier `mul`.
- Accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO.
- Issues one-cycle `start` pulses to the multiplier only when it is idle, waits a fixed latency, then captures the product and presents it downstream over valid/ready.
- Turns the multiplier's bare start/busy interface into a streaming, back-pressured pipeline stage.

Parameters:
- WIDTH, 32: operand and result width; must match the multiplier.
- DEPTH, 4: operand FIFO entries; power of 2, minimum 2.
- MUL_LATENCY, 34: cycles from `mul_start` sampled to `mul_out` valid.

Ports:
- clk  in  1  clock; all flops on rising edge.
- rst  in  1  asynchronous, active-low reset.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  FIFO can accept a pair.
- op_a  in  WIDTH  multiplicand.
- op_b  in  WIDTH  multiplier operand.
- res_valid  out  1  product valid.
- res_ready  in  1  downstream accepts product.
- res_data  out  WIDTH  product (low WIDTH bits).
- mul_in1  out  WIDTH  to multiplier `in1`; registered.
- mul_in2  out  WIDTH  to multiplier `in2`; registered.
- mul_start  out  1  one-cycle start pulse.
- mul_busy  in  1  multiplier busy.
- mul_out  in  WIDTH  multiplier result.
- fifo_empty  out  1  FIFO holds no pairs.
- fifo_full  out  1  FIFO holds DEPTH pairs.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO pointers and count go to 0.
  - FSM goes to IDLE.
  - mul_start, res_valid, mul_in1, mul_in2, res_data and the latency counter go to 0.
  - fifo_empty=1, fifo_full=0, op_ready=1.
  - Reset mid-operation discards all queued and in-flight work; no result is emitted.
- Push:
  - A pair is written on a clk edge where op_valid and op_ready are both 1.
  - op_ready = !fifo_full. There is no bypass: when full, a same-cycle pop does not free a slot until the next cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- FSM:
  - IDLE:
    - If !fifo_empty and !mul_busy: load mul_in1/mul_in2 from the FIFO head, pop, assert mul_start, then go to ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE:
    - mul_start=1 for exactly this cycle.
    - Clear the counter, then go to WAIT.
  - WAIT:
    - Increment the counter every cycle.
    - When counter == MUL_LATENCY-1: capture mul_out into res_data, set res_valid=1, go to HOLD.
    - mul_in1/mul_in2 stay stable throughout.
  - HOLD:
    - res_valid=1 and res_data stable until res_ready=1.
    - On that edge: clear res_valid, go to IDLE.
- Latency:
  - A pair pushed into an empty FIFO with an idle FSM at edge E0 gives res_valid high after edge E0+MUL_LATENCY+2.
  - With back-to-back pairs and res_ready held at 1, throughput is one result per MUL_LATENCY+3 cycles.
- Ordering: results are strictly in push order, with one operation in flight at a time.
- Width: res_data is exactly the multiplier's WIDTH-bit output. Overflow bits are dropped, never flagged.
- mul_busy sampled high in IDLE defers issue indefinitely. mul_busy is ignored in WAIT and HOLD.

Optional Feature:
- Macro: MUL_DISPATCH_STATS_EN.
- When defined, add output `done_count` (16 bits), reset to 0.
  - Increments on every res_valid & res_ready edge.
  - Wraps 0xFFFF -> 0x0000.
- When undefined, the port and its counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package `mul_pkg` holds:
  - FSM state encodings IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, HOLD=2'b11.
  - The default WIDTH and MUL_LATENCY constants, shared with the multiplier.
- One sub-module, `mul_op_fifo`:
  - Parameterised synchronous FIFO of 2*WIDTH-bit entries.
  - Has push/pop/empty/full and the same asynchronous active-low reset.
  - The FSM lives in mul_dispatch.

Test Plan:
- Reset, then push (op_a=3, op_b=5) with res_ready=1:
  - mul_start pulses once, one cycle after the push edge.
  - res_data=15 and res_valid=1 after edge E0+36; res_valid clears the following cycle.
- Push (0x0000FFFF, 0x00010001): res_data=0xFFFFFFFF. Push (0xFFFFFFFF, 2): res_data=0xFFFFFFFE (overflow dropped).
- Push 5 pairs back-to-back with res_ready=0:
  - fifo_full=1 and op_ready=0 after the 5th pair is accepted (4 in the FIFO, 1 held).
  - Releasing res_ready yields all 5 products in order.
- Hold mul_busy=1 with 2 pairs queued: no mul_start, FSM stays in IDLE. Drop mul_busy: issue starts on the next edge.
- Assert rst=0 during WAIT with 3 pairs queued:
  - All outputs return to reset values immediately.
  - No result is emitted after release; fifo_empty=1.
- With MUL_DISPATCH_STATS_EN: done_count=3 after 3 completed handshakes. Preload near 0xFFFF to check wrap to 0.
